sha512_round_ctrl: RTL
======================

// Module: sha512_round_ctrl
// PURPOSE
//   Control FSM for the SHA-512 core with 32-bit input. Drives the round counter's
//   clr_j/cnt_j_en and reads back its 7-bit count j.
//   Sequences each block through three phases:
//     - load message in 32-bit beats,
//     - run the rounds,
//     - update the hash.
//   After the last block it streams the digest out. Sits between the host
//   handshake and the datapath/counter.
// PARAMETERS
//   JW         7   width of j (must hold max(ROUNDS,LOAD_BEATS)-1)
//   LOAD_BEATS 32  32-bit input beats per 1024-bit block
//   ROUNDS     80  compression rounds per block
//   OUT_BEATS  16  32-bit digest output beats (512-bit digest)
// PORTS
//   i_clk        in   1   clock
//   i_rst        in   1   asynchronous reset, active-low
//   i_start      in   1   start new message (sampled in IDLE only)
//   i_abort      in   1   synchronous abort, any state
//   i_in_valid   in   1   input beat valid
//   i_in_last    in   1   current block is final block (sampled on final load beat)
//   o_in_ready   out  1   ready for input beat
//   j            in   JW  current count from round counter
//   clr_j        out  1   clear round counter (next edge)
//   cnt_j_en     out  1   increment round counter (next edge)
//   o_init_hash  out  1   load IV into hash regs (1-cycle pulse)
//   o_load_en    out  1   write input beat into message buffer, index j
//   o_round_en   out  1   datapath executes round j this cycle
//   o_w_sel      out  1   0: W from message buffer (j<16), 1: from schedule
//   o_k_addr     out  JW  K-constant ROM address (= j in ROUND)
//   o_update_hash out 1   add working vars into hash regs (1-cycle)
//   o_out_valid  out  1   digest beat valid
//   i_out_ready  in   1   sink accepts digest beat
//   o_out_idx    out  4   digest beat index (= j[3:0] in OUTPUT)
//   o_busy       out  1   state != IDLE
//   o_done       out  1   registered 1-cycle pulse after final digest beat accepted
// BEHAVIOUR
//   State: IDLE, LOAD, ROUND, UPDATE, OUTPUT. Registered: state, last_flag, o_done.
//   All other outputs are combinational from state, j and handshakes.
//   Reset: state=IDLE, last_flag=0, o_done=0. Hence clr_j=1 and all other outputs 0.
//   IDLE: clr_j=1 continuously (j is 0 on exit).
//     i_start=1 -> o_init_hash=1 this cycle; next state LOAD.
//   LOAD: o_in_ready=1.
//     beat = i_in_valid & o_in_ready -> o_load_en=1, cnt_j_en=1.
//     On beat with j==LOAD_BEATS-1: cnt_j_en=0, clr_j=1, last_flag<=i_in_last, -> ROUND.
//     No beat: j holds; no timeout.
//   ROUND: o_round_en=1, o_k_addr=j, o_w_sel=(j>=16), cnt_j_en=1 every cycle.
//     j==ROUNDS-1: cnt_j_en=0, clr_j=1, -> UPDATE. Exactly ROUNDS cycles in ROUND.
//   UPDATE: exactly 1 cycle, o_update_hash=1, clr_j=1.
//     last_flag=0 -> LOAD (next block, hash chained); last_flag=1 -> OUTPUT.
//   OUTPUT: o_out_valid=1, o_out_idx=j[3:0].
//     accept = o_out_valid & i_out_ready -> cnt_j_en=1.
//     accept with j==OUT_BEATS-1: clr_j=1, o_done<=1, -> IDLE.
//     Stall (ready=0): j and idx hold, valid stays high.
//   Priority: i_abort over everything. Abort -> clr_j=1, cnt_j_en=0,
//     all strobes 0, next state IDLE, last_flag<=0, no o_done.
//   clr_j and cnt_j_en are never both 1. o_in_ready=0 outside LOAD.
//   i_start ignored when not IDLE.
//   Async reset mid-operation: immediate IDLE; the counter is cleared by its own reset.
//   Latency: single block = 32 beats + 80 + 1 + 16 beats; min start->o_done = 130 cycles.
// TESTING
//   1. Reset, then i_start=1 one cycle -> o_init_hash pulse; o_busy=1;
//      o_in_ready=1 next cycle with j=0.
//   2. Single block, valid every cycle, i_in_last=1, out_ready=1
//      -> 32 o_load_en, 80 o_round_en (k_addr 0..79, w_sel rises at j=16),
//      1 o_update_hash, 16 out beats idx 0..15, o_done at cycle 130.
//   3. Two blocks (i_in_last=0 then 1)
//      -> UPDATE returns to LOAD, no o_init_hash; 2x80 rounds; single 16-beat output.
//   4. Back-pressure: valid toggles 1/0 in LOAD; out_ready=0 for 5 cycles at idx 7
//      -> j/idx hold, o_out_valid stays 1, no beat lost or duplicated.
//   5. i_abort at ROUND j=40 -> next cycle IDLE, j cleared to 0, no o_update_hash/o_done;
//      subsequent i_start runs clean.
//   6. i_rst low during OUTPUT idx 5 -> IDLE immediately, o_out_valid=0, o_done=0;
//      i_start after release -> normal run.

Source files
------------

// File: rtl/sha512_round_ctrl.sv
// Sequencing FSM for the SHA-512 core: load 32-bit beats, run the rounds, update the hash,
// then stream the digest. The round counter j lives outside; this block only clears/steps it.
//
// state  | meaning
// IDLE   | waiting for i_start, round counter held clear
// LOAD   | accepting LOAD_BEATS input beats into the message buffer
// ROUND  | datapath runs round j, ROUNDS cycles
// UPDATE | one cycle, working vars added into hash regs
// OUTPUT | streaming OUT_BEATS digest beats to the sink
module sha512_round_ctrl #(
  parameter int JW         = 7,
  parameter int LOAD_BEATS = 32,
  parameter int ROUNDS     = 80,
  parameter int OUT_BEATS  = 16
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic          i_abort,
  input  logic          i_in_valid,
  input  logic          i_in_last,
  output logic          o_in_ready,
  input  logic [JW-1:0] j,
  output logic          clr_j,
  output logic          cnt_j_en,
  output logic          o_init_hash,
  output logic          o_load_en,
  output logic          o_round_en,
  output logic          o_w_sel,
  output logic [JW-1:0] o_k_addr,
  output logic          o_update_hash,
  output logic          o_out_valid,
  input  logic          i_out_ready,
  output logic [3:0]    o_out_idx,
  output logic          o_busy,
  output logic          o_done
);

  localparam logic [JW-1:0] LOAD_LAST  = JW'(LOAD_BEATS - 1);
  localparam logic [JW-1:0] ROUND_LAST = JW'(ROUNDS - 1);
  localparam logic [JW-1:0] OUT_LAST   = JW'(OUT_BEATS - 1);
  localparam logic [JW-1:0] SCHED_J    = JW'(16);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    ROUND  = 3'd2,
    UPDATE = 3'd3,
    OUTPUT = 3'd4
  } state_t;

  state_t state, state_nxt;
  logic   last_flag, last_flag_nxt;
  logic   done_nxt;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state     <= IDLE;
      last_flag <= 1'b0;
      o_done    <= 1'b0;
    end else begin
      state     <= state_nxt;
      last_flag <= last_flag_nxt;
      o_done    <= done_nxt;
    end
  end

  assign o_busy = (state != IDLE);

  always_comb begin
    state_nxt     = state;
    last_flag_nxt = last_flag;
    done_nxt      = 1'b0;
    clr_j         = 1'b0;
    cnt_j_en      = 1'b0;
    o_in_ready    = 1'b0;
    o_init_hash   = 1'b0;
    o_load_en     = 1'b0;
    o_round_en    = 1'b0;
    o_w_sel       = 1'b0;
    o_k_addr      = '0;
    o_update_hash = 1'b0;
    o_out_valid   = 1'b0;
    o_out_idx     = '0;

    // Abort silences every strobe and handshake, and parks the counter at zero.
    if (i_abort) begin
      clr_j         = 1'b1;
      last_flag_nxt = 1'b0;
      state_nxt     = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          clr_j = 1'b1;
          if (i_start) begin
            o_init_hash = 1'b1;
            state_nxt   = LOAD;
          end
        end
        LOAD: begin
          o_in_ready = 1'b1;
          if (i_in_valid) begin
            o_load_en = 1'b1;
            if (j == LOAD_LAST) begin
              clr_j         = 1'b1;
              last_flag_nxt = i_in_last;
              state_nxt     = ROUND;
            end else begin
              cnt_j_en = 1'b1;
            end
          end
        end
        ROUND: begin
          o_round_en = 1'b1;
          o_k_addr   = j;
          o_w_sel    = (j >= SCHED_J);
          if (j == ROUND_LAST) begin
            clr_j     = 1'b1;
            state_nxt = UPDATE;
          end else begin
            cnt_j_en = 1'b1;
          end
        end
        UPDATE: begin
          o_update_hash = 1'b1;
          clr_j         = 1'b1;
          state_nxt     = last_flag ? OUTPUT : LOAD;
        end
        OUTPUT: begin
          o_out_valid = 1'b1;
          o_out_idx   = j[3:0];
          if (i_out_ready) begin
            if (j == OUT_LAST) begin
              clr_j     = 1'b1;
              done_nxt  = 1'b1;
              state_nxt = IDLE;
            end else begin
              cnt_j_en = 1'b1;
            end
          end
        end
        default: begin
          clr_j     = 1'b1;
          state_nxt = IDLE;
        end
      endcase
    end
  end

endmodule
